// File: rtl/regfile_alu_if.sv
// regfile_alu_if: command/status/debug bundle for regfile_alu.
// master drives start/op/rd/rs1/rs2/imm/dbg_addr; slave drives
// busy/done/result/carry/dbg_data.
interface regfile_alu_if #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
);
  logic             start;
  logic [1:0]       op;
  logic [AW-1:0]    rd;
  logic [AW-1:0]    rs1;
  logic [AW-1:0]    rs2;
  logic [WIDTH-1:0] imm;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic [AW-1:0]    dbg_addr;
  logic [WIDTH-1:0] dbg_data;

  modport master (
    output start, op, rd, rs1, rs2, imm, dbg_addr,
    input  busy, done, result, carry, dbg_data
  );

  modport slave (
    input  start, op, rd, rs1, rs2, imm, dbg_addr,
    output busy, done, result, carry, dbg_data
  );
endinterface

// File: rtl/regfile_alu.sv
// regfile_alu: 2**AW-entry register file feeding a WIDTH-bit
// add/sub unit, sequenced IDLE->READ->EXEC->WRITE.
// Ports: clk; reset (sync, active-high); bus (slave modport):
//   in  start, op, rd, rs1, rs2, imm, dbg_addr
//   out busy, done, result, carry, dbg_data (comb R[dbg_addr])
module regfile_alu #(
  parameter int WIDTH = 8,
  parameter int AW    = 3
) (
  input  logic         clk,
  input  logic         reset,
  regfile_alu_if.slave bus
);
  localparam int NREG = 2**AW;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC,
    WRITE
  } state_t;

  typedef struct packed {
    logic [1:0]       op;
    logic [AW-1:0]    rd;
    logic [AW-1:0]    rs1;
    logic [AW-1:0]    rs2;
    logic [WIDTH-1:0] imm;
  } cmd_t;

  state_t           state_q;
  state_t           state_d;
  cmd_t             cmd_q;
  logic [WIDTH-1:0] rf [NREG];
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             busy_q;
  logic             done_q;
  logic [WIDTH:0]   sum;
  logic [NREG-1:0]  we;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = READ;
      READ:    state_d = EXEC;
      EXEC:    state_d = WRITE;
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // B already holds imm for op 1x, so op 11 is a plain add.
  always_comb begin
    sum = '0;
    case (cmd_q.op)
      2'b00:   sum = {1'b0, a_q} + {1'b0, b_q};
      2'b01:   sum = {1'b0, a_q} - {1'b0, b_q};
      2'b10:   sum = {1'b0, cmd_q.imm};
      default: sum = {1'b0, a_q} + {1'b0, b_q};
    endcase
  end

  // One-hot write enable from rd, live only in WRITE.
  always_comb begin
    we = '0;
    for (int i = 0; i < NREG; i++) begin
      we[i] = (state_q == WRITE) && (cmd_q.rd == AW'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cmd_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        rf[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d != IDLE);
      done_q  <= (state_d == WRITE);
      if (state_q == IDLE && bus.start) begin
        cmd_q <= '{
          op:  bus.op,
          rd:  bus.rd,
          rs1: bus.rs1,
          rs2: bus.rs2,
          imm: bus.imm
        };
      end
      if (state_q == READ) begin
        a_q <= rf[cmd_q.rs1];
        b_q <= cmd_q.op[1] ? cmd_q.imm
                           : rf[cmd_q.rs2];
      end
      if (state_q == EXEC) begin
        {carry_q, result_q} <= sum;
      end
      for (int i = 0; i < NREG; i++) begin
        if (we[i]) rf[i] <= result_q;
      end
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.carry    = carry_q;
  assign bus.dbg_data = rf[bus.dbg_addr];
endmodule
